mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and data-memory (MEM-stage) port. Data accesses win by default. An anti-starvation counter forces an IF grant after repeated losses. Per-port stall outputs freeze the pipeline while a port waits. A watchdog turns a hung memory into a flagged error instead of a deadlock.

---
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch (IF)
// port and the data (MEM-stage) port of the pipeline. Data accesses win by
// default. A starvation counter forces an IF grant after STARVE_LIM
// consecutive IF losses. A watchdog aborts a memory access that never
// completes, and it raises a sticky bus_err instead of deadlocking the
// pipeline.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   if_req     fetch request, held with stable if_addr until if_ack
//   if_addr    fetch address
//   if_rdata   fetched word, valid while if_ack=1
//   if_ack     one-cycle fetch completion pulse
//   d_req_rd   data read request
//   d_req_wr   data write request (wins when both rd and wr are high)
//   d_addr     data address
//   d_wdata    data write data
//   d_rdata    data read data, valid while d_ack=1
//   d_ack      one-cycle data completion pulse
//   stall_if   fetch port is waiting (combinational)
//   stall_mem  data port is waiting (combinational)
//   mem_req    registered memory access strobe
//   mem_we     registered memory write enable
//   mem_addr   registered memory address
//   mem_wdata  registered memory write data
//   mem_rdata  memory read data, sampled when mem_ready=1
//   mem_ready  memory completion, may be high in the first mem_req cycle
//   bus_err    sticky memory timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_LIM = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req_rd,
   input  logic              d_req_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              bus_err
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_D,
      RESP
   } state_t;

   localparam logic [3:0] StarveLim = 4'(STARVE_LIM);
   localparam logic [7:0] Timeout   = 8'(TIMEOUT);

   state_t            state_q, state_d;
   logic [3:0]        starveCnt_q, starveCnt_d;
   logic [7:0]        wdogCnt_q, wdogCnt_d;
   logic              gntD_q, gntD_d;
   logic              memReq_q, memReq_d;
   logic              memWe_q, memWe_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic [DATA_W-1:0] memWdata_q, memWdata_d;
   logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
   logic [DATA_W-1:0] dRdata_q, dRdata_d;
   logic              busErr_q, busErr_d;

   logic              dReq;
   logic              forceIf;
   logic [7:0]        wdogInc;

   // State register. Reset drops mem_req at once, even mid-transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         starveCnt_q <= '0;
         wdogCnt_q   <= '0;
         gntD_q      <= 1'b0;
         memReq_q    <= 1'b0;
         memWe_q     <= 1'b0;
         memAddr_q   <= '0;
         memWdata_q  <= '0;
         ifRdata_q   <= '0;
         dRdata_q    <= '0;
         busErr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         starveCnt_q <= starveCnt_d;
         wdogCnt_q   <= wdogCnt_d;
         gntD_q      <= gntD_d;
         memReq_q    <= memReq_d;
         memWe_q     <= memWe_d;
         memAddr_q   <= memAddr_d;
         memWdata_q  <= memWdata_d;
         ifRdata_q   <= ifRdata_d;
         dRdata_q    <= dRdata_d;
         busErr_q    <= busErr_d;
      end
   end

   // Arbitration, memory handshake and watchdog. Everything holds its value
   // unless a transition below changes it.
   always_comb begin
      state_d     = state_q;
      starveCnt_d = starveCnt_q;
      wdogCnt_d   = wdogCnt_q;
      gntD_d      = gntD_q;
      memReq_d    = memReq_q;
      memWe_d     = memWe_q;
      memAddr_d   = memAddr_q;
      memWdata_d  = memWdata_q;
      ifRdata_d   = ifRdata_q;
      dRdata_d    = dRdata_q;
      busErr_d    = busErr_q;

      dReq    = d_req_rd | d_req_wr;
      forceIf = if_req && (starveCnt_q == StarveLim);
      wdogInc = wdogCnt_q + 8'd1;

      case (state_q)
         IDLE: begin
            wdogCnt_d = '0;
            if (forceIf || (if_req && !dReq)) begin
               state_d     = BUSY_IF;
               gntD_d      = 1'b0;
               memReq_d    = 1'b1;
               memWe_d     = 1'b0;
               memAddr_d   = if_addr;
               memWdata_d  = '0;
               starveCnt_d = '0;
            end else if (dReq) begin
               state_d    = BUSY_D;
               gntD_d     = 1'b1;
               memReq_d   = 1'b1;
               memWe_d    = d_req_wr;
               memAddr_d  = d_addr;
               memWdata_d = d_wdata;
               // Only a loss by a waiting fetch counts toward starvation.
               if (if_req && (starveCnt_q != StarveLim)) begin
                  starveCnt_d = starveCnt_q + 4'd1;
               end
            end
         end

         BUSY_IF, BUSY_D: begin
            wdogCnt_d = wdogInc;
            if (mem_ready) begin
               memReq_d = 1'b0;
               memWe_d  = 1'b0;
               state_d  = RESP;
               if (state_q == BUSY_IF) begin
                  ifRdata_d = mem_rdata;
               end else begin
                  dRdata_d = memWe_q ? '0 : mem_rdata;
               end
            end else if (wdogInc == Timeout) begin
               // Hung memory: abort, flag it, and hand back zero data.
               memReq_d = 1'b0;
               memWe_d  = 1'b0;
               busErr_d = 1'b1;
               state_d  = RESP;
               if (state_q == BUSY_IF) begin
                  ifRdata_d = '0;
               end else begin
                  dRdata_d = '0;
               end
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign if_ack    = (state_q == RESP) && !gntD_q;
   assign d_ack     = (state_q == RESP) && gntD_q;
   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = (d_req_rd | d_req_wr) & ~d_ack;

   assign mem_req   = memReq_q;
   assign mem_we    = memWe_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign if_rdata  = ifRdata_q;
   assign d_rdata   = dRdata_q;
   assign bus_err   = busErr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Two port drivers replay queued
// requests, a small memory model answers mem_req with a programmable number
// of wait states (or never), and a monitor pops the expected ack sequence
// from a scoreboard queue whenever the DUT acknowledges a port.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          d_req_rd = 1'b0;
   logic          d_req_wr = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          stall_if;
   logic          stall_mem;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic          bus_err;

   mem_port_arbiter #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .STARVE_LIM(4),
      .TIMEOUT   (15)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_ack   (if_ack),
      .d_req_rd (d_req_rd),
      .d_req_wr (d_req_wr),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_ack    (d_ack),
      .stall_if (stall_if),
      .stall_mem(stall_mem),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .bus_err  (bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } dTxn_t;

   typedef struct {
      logic          isD;
      logic [DW-1:0] data;
   } exp_t;

   dTxn_t         dQ[$];
   logic [AW-1:0] ifQ[$];
   exp_t          expQ[$];

   bit dActive  = 1'b0;
   bit ifActive = 1'b0;
   int dWait    = 0;
   int ifWait   = 0;

   int readyDelay = 0;
   bit noReady    = 1'b0;
   int seen       = 0;
   logic [DW-1:0] memArr [0:255];

   int checks = 0;
   int errors = 0;

   // Single comparison point; every result flows through here.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // An expired wait bound counts as a failed comparison.
   task automatic reportTimeout(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: bound expired before the DUT responded", name);
   endtask

   // Data port driver: hold each request until d_ack, then issue the next
   // one immediately so back-to-back requests stay asserted.
   initial begin : dDriver
      dTxn_t t;
      forever begin
         @(negedge clk);
         if (dActive && d_ack) begin
            dActive  = 1'b0;
            d_req_rd = 1'b0;
            d_req_wr = 1'b0;
         end
         if (dActive) begin
            dWait++;
            if (dWait > 300) begin
               reportTimeout("d_ack wait");
               dActive  = 1'b0;
               d_req_rd = 1'b0;
               d_req_wr = 1'b0;
            end
         end else if (dQ.size() > 0) begin
            t        = dQ.pop_front();
            d_req_rd = t.rd;
            d_req_wr = t.wr;
            d_addr   = t.addr;
            d_wdata  = t.wdata;
            dActive  = 1'b1;
            dWait    = 0;
         end
      end
   end

   // Fetch port driver, same protocol as the data driver.
   initial begin : ifDriver
      forever begin
         @(negedge clk);
         if (ifActive && if_ack) begin
            ifActive = 1'b0;
            if_req   = 1'b0;
         end
         if (ifActive) begin
            ifWait++;
            if (ifWait > 300) begin
               reportTimeout("if_ack wait");
               ifActive = 1'b0;
               if_req   = 1'b0;
            end
         end else if (ifQ.size() > 0) begin
            if_addr  = ifQ.pop_front();
            if_req   = 1'b1;
            ifActive = 1'b1;
            ifWait   = 0;
         end
      end
   end

   // Memory model: answers after readyDelay wait states, or never when
   // noReady is set. Writes return junk on mem_rdata to expose leaks.
   initial begin : responder
      for (int i = 0; i < 256; i++) begin
         memArr[i] = 32'h1000_0000 | 32'(i);
      end
      memArr[8'h10] = 32'h2002_000A;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            if (!noReady && (seen == readyDelay)) begin
               mem_ready = 1'b1;
               if (mem_we) begin
                  memArr[mem_addr[9:2]] = mem_wdata;
                  mem_rdata = 32'hBAD0_BAD0;
               end else begin
                  mem_rdata = memArr[mem_addr[9:2]];
               end
            end else begin
               mem_ready = 1'b0;
            end
            seen++;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = '0;
            seen      = 0;
         end
      end
   end

   // Monitor: every ack must match the next scoreboard entry in port and data.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (if_ack && d_ack) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack overlap: if_ack=%0b d_ack=%0b required at most one", if_ack, d_ack);
         end
         if (if_ack || d_ack) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected ack: if_ack=%0b d_ack=%0b with empty scoreboard", if_ack, d_ack);
            end else begin
               e = expQ.pop_front();
               checkOutput("ack port is D", 64'(d_ack), 64'(e.isD));
               checkOutput("ack data", 64'(d_ack ? d_rdata : if_rdata), 64'(e.data));
            end
         end
      end
   end

   // Wait (bounded) until the arbiter launches a memory access.
   task automatic waitMemReq(input string name);
      int n;
      n = 0;
      while (!mem_req && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!mem_req) reportTimeout(name);
   endtask

   // Wait (bounded) until all queued requests are acknowledged.
   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while ((dQ.size() > 0 || ifQ.size() > 0 || dActive || ifActive || expQ.size() > 0) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (dQ.size() > 0 || ifQ.size() > 0 || dActive || ifActive || expQ.size() > 0) begin
         reportTimeout(name);
      end
   endtask

   // Queue one expected ack and the request that produces it.
   task automatic applyStimulus(input bit isD, input logic rd, input logic wr,
                                input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                input logic [DW-1:0] expData);
      expQ.push_back('{isD, expData});
      if (isD) dQ.push_back('{rd, wr, addr, wdata});
      else     ifQ.push_back(addr);
   endtask

   // Safety net so a hung DUT can never stall the run.
   initial begin : globalTimeout
      #500000;
      $display("[TB] FAIL global timeout: simulation did not finish");
      $fatal(1, "[TB] aborting");
   end

   // Directed test sequence.
   initial begin : mainSeq
      int busyCycles;

      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset mem_req", 64'(mem_req), 64'd0);
      checkOutput("reset mem_we", 64'(mem_we), 64'd0);
      checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("reset acks", 64'({if_ack, d_ack}), 64'd0);
      checkOutput("reset bus_err", 64'(bus_err), 64'd0);
      checkOutput("reset rdata", 64'({if_rdata, d_rdata}), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 1: single fetch, memory ready in the first mem_req cycle.
      $display("[TB] test 1: single fetch");
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h40, '0, 32'h2002_000A);
      @(negedge clk);
      #1;
      checkOutput("t1 stall_if cycle0", 64'(stall_if), 64'd1);
      checkOutput("t1 mem_req cycle0", 64'(mem_req), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("t1 mem_req cycle1", 64'(mem_req), 64'd1);
      checkOutput("t1 mem_addr cycle1", 64'(mem_addr), 64'h40);
      checkOutput("t1 mem_we cycle1", 64'(mem_we), 64'd0);
      checkOutput("t1 stall_if cycle1", 64'(stall_if), 64'd1);
      checkOutput("t1 if_ack cycle1", 64'(if_ack), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("t1 if_ack cycle2", 64'(if_ack), 64'd1);
      checkOutput("t1 if_rdata cycle2", 64'(if_rdata), 64'h2002_000A);
      checkOutput("t1 stall_if cycle2", 64'(stall_if), 64'd0);
      checkOutput("t1 mem_req cycle2", 64'(mem_req), 64'd0);
      waitDrain("t1 drain");

      // 2: simultaneous fetch and write, data wins first.
      $display("[TB] test 2: fetch vs data write");
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h48, '0, 32'h1000_0012);
      waitMemReq("t2 mem_req");
      checkOutput("t2 mem_we", 64'(mem_we), 64'd1);
      checkOutput("t2 mem_addr", 64'(mem_addr), 64'h100);
      checkOutput("t2 mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      checkOutput("t2 stall_if while D busy", 64'(stall_if), 64'd1);
      checkOutput("t2 stall_mem while D busy", 64'(stall_mem), 64'd1);
      waitDrain("t2 drain");

      // 2b: rd and wr both high is a write; read it back afterwards.
      $display("[TB] test 2b: rd+wr together is a write");
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 32'h0);
      waitMemReq("t2b mem_req");
      checkOutput("t2b mem_we", 64'(mem_we), 64'd1);
      waitDrain("t2b drain");
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h104, '0, 32'hCAFE_F00D);
      waitDrain("t2b readback drain");

      // 3: starvation, four D wins then a forced IF grant.
      $display("[TB] test 3: starvation");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * i), '0, 32'h1000_0080 + 32'(i));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h44, '0, 32'h1000_0011);
      for (int i = 4; i < 6; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * i), '0, 32'h1000_0080 + 32'(i));
      end
      waitDrain("t3 drain");

      // 4: three wait states on a D read.
      $display("[TB] test 4: memory wait states");
      readyDelay = 3;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, '0, 32'hDEAD_BEEF);
      waitMemReq("t4 mem_req");
      for (int i = 0; i < 3; i++) begin
         checkOutput("t4 mem_req held", 64'(mem_req), 64'd1);
         checkOutput("t4 mem_addr held", 64'(mem_addr), 64'h100);
         @(posedge clk);
         #1;
      end
      checkOutput("t4 mem_req ready cycle", 64'(mem_req), 64'd1);
      checkOutput("t4 d_ack ready cycle", 64'(d_ack), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("t4 d_ack after ready", 64'(d_ack), 64'd1);
      checkOutput("t4 d_rdata", 64'(d_rdata), 64'hDEAD_BEEF);
      waitDrain("t4 drain");
      readyDelay = 0;

      // 5: memory never answers, watchdog aborts after 15 BUSY cycles.
      $display("[TB] test 5: timeout");
      noReady = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, '0, 32'h0);
      waitMemReq("t5 mem_req");
      busyCycles = 0;
      while (mem_req && busyCycles < 40) begin
         busyCycles++;
         @(posedge clk);
         #1;
      end
      checkOutput("t5 busy cycles", 64'(busyCycles), 64'd15);
      checkOutput("t5 d_ack on abort", 64'(d_ack), 64'd1);
      checkOutput("t5 bus_err", 64'(bus_err), 64'd1);
      checkOutput("t5 d_rdata", 64'(d_rdata), 64'd0);
      noReady = 1'b0;
      waitDrain("t5 drain");
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h4C, '0, 32'h1000_0013);
      waitDrain("t5 recovery drain");
      checkOutput("t5 bus_err sticky", 64'(bus_err), 64'd1);

      // 6: asynchronous reset in the middle of BUSY_D.
      $display("[TB] test 6: reset mid-BUSY");
      noReady = 1'b1;
      dQ.push_back('{1'b1, 1'b0, 32'h50, 32'h0});
      waitMemReq("t6 mem_req");
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("t6 mem_req in reset", 64'(mem_req), 64'd0);
      checkOutput("t6 mem_addr in reset", 64'(mem_addr), 64'd0);
      checkOutput("t6 acks in reset", 64'({if_ack, d_ack}), 64'd0);
      checkOutput("t6 bus_err in reset", 64'(bus_err), 64'd0);
      checkOutput("t6 if_rdata in reset", 64'(if_rdata), 64'd0);
      dActive  = 1'b0;
      d_req_rd = 1'b0;
      d_req_wr = 1'b0;
      noReady  = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h54, '0, 32'h1000_0015);
      waitMemReq("t6 mem_req after reset");
      checkOutput("t6 mem_addr after reset", 64'(mem_addr), 64'h54);
      waitDrain("t6 drain");
      checkOutput("t6 bus_err after reset", 64'(bus_err), 64'd0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
